// File: rtl/ncl_host_pkg.sv
// ncl_host_pkg: shared FSM states, dual-rail codes and helpers for the NCL multiplier host
package ncl_host_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, SEND_NULL, WAIT_NULL, RESULT} state_t;
  typedef struct packed {
    logic r1;
    logic r0;
  } dr_t;
  localparam dr_t DR_NULL  = 2'b00;
  localparam dr_t DR_DATA0 = 2'b01;
  localparam dr_t DR_DATA1 = 2'b10;
  function automatic logic dr_is_data(input dr_t d);
    return d == DR_DATA0 || d == DR_DATA1;
  endfunction
  function automatic logic dr_is_null(input dr_t d);
    return d == DR_NULL;
  endfunction
  function automatic logic dr_is_illegal(input dr_t d);
    return d.r1 && d.r0;
  endfunction
endpackage

// File: rtl/ncl_dr_sync.sv
// ncl_dr_sync: multi-stage synchronizer for N asynchronous dual-rail pairs with per-pair code flags
module ncl_dr_sync
  import ncl_host_pkg::*;
#(
  parameter int N = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] r1,
  input  logic [N-1:0] r0,
  output logic [N-1:0] s_r1,
  output logic [N-1:0] s_r0,
  output logic [N-1:0] pair_complete,
  output logic [N-1:0] pair_null,
  output logic [N-1:0] pair_illegal
);
  logic [2*N-1:0] sh [STAGES];
  // shift both rails through STAGES flops before anything looks at them
  always_ff @(posedge clk)
    if (rst) for (int k = 0; k < STAGES; k++) sh[k] <= '0;
    else begin
      sh[0] <= {r1, r0};
      for (int k = 1; k < STAGES; k++) sh[k] <= sh[k-1];
    end
  assign {s_r1, s_r0} = sh[STAGES-1];
  for (genvar i = 0; i < N; i++) begin : g_pair
    dr_t pr;
    assign pr = {s_r1[i], s_r0[i]};
    assign pair_complete[i] = dr_is_data(pr);
    assign pair_null[i] = dr_is_null(pr);
    assign pair_illegal[i] = dr_is_illegal(pr);
  end
endmodule

// File: rtl/ncl_mult3_host.sv
// ncl_mult3_host: synchronous host driving a 3x3 NCL dual-rail multiplier through DATA/NULL wavefronts
module ncl_mult3_host
  import ncl_host_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_a,
  input  logic [2:0] op_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_p,
  output logic       res_err,
  output logic [2:0] ncl_a_r1,
  output logic [2:0] ncl_a_r0,
  output logic [2:0] ncl_b_r1,
  output logic [2:0] ncl_b_r0,
  output logic       ncl_ki,
  input  logic [5:0] ncl_po_r1,
  input  logic [5:0] ncl_po_r0,
  input  logic       ncl_ko
);
  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] ko_sh;
  logic ko_s;
  logic [5:0] p_r1, p_r0, pc, pn, pi;
  logic [11:0] prev;
  logic [SW-1:0] scnt, run;
  logic [TW-1:0] tcnt;
  logic accept, stable, tmo, waiting, p_illegal;
  logic [5:0] res_p_n;
  logic res_err_n;
  ncl_dr_sync #(.N(6), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .r1(ncl_po_r1),
    .r0(ncl_po_r0),
    .s_r1(p_r1),
    .s_r0(p_r0),
    .pair_complete(pc),
    .pair_null(pn),
    .pair_illegal(pi)
  );
  assign ko_s = ko_sh[SYNC_STAGES-1];
  assign accept = op_valid && op_ready;
  assign waiting = state == WAIT_DATA || state == WAIT_NULL;
  assign p_illegal = |pi;
  assign tmo = tcnt == TW'(TIMEOUT_CYC - 1);
  assign run = !(state == WAIT_DATA ? &pc : &pn) ? '0 :
               ({p_r1, p_r0} == prev && scnt != '0) ? (scnt == SW'(STABLE_CYC) ? scnt : scnt + 1'b1) : SW'(1);
  assign stable = run == SW'(STABLE_CYC);
  // next state and result capture; illegal codes beat a good wavefront, which beats a timeout
  always_comb begin
    state_n = state;
    res_p_n = res_p;
    res_err_n = res_err;
    case (state)
      IDLE: if (accept) begin
        state_n = WAIT_DATA;
        res_p_n = '0;
        res_err_n = 1'b0;
      end
      WAIT_DATA:
        if (p_illegal || (tmo && !(stable && !ko_s))) begin
          state_n = SEND_NULL;
          res_p_n = '0;
          res_err_n = 1'b1;
        end else if (stable && !ko_s) begin
          state_n = SEND_NULL;
          res_p_n = p_r1;
        end
      SEND_NULL: state_n = WAIT_NULL;
      WAIT_NULL:
        if (stable && ko_s) state_n = RESULT;
        else if (tmo) begin
          state_n = RESULT;
          res_p_n = '0;
          res_err_n = 1'b1;
        end
      RESULT: if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // all outputs are registered from the next-state decision so no input reaches an output combinationally
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ko_sh <= '0;
      prev <= '0;
      scnt <= '0;
      tcnt <= '0;
      res_p <= '0;
      res_err <= 1'b0;
      res_valid <= 1'b0;
      op_ready <= 1'b0;
      ncl_ki <= 1'b0;
      ncl_a_r1 <= '0;
      ncl_a_r0 <= '0;
      ncl_b_r1 <= '0;
      ncl_b_r0 <= '0;
    end else begin
      state <= state_n;
      ko_sh <= SYNC_STAGES'({ko_sh, ncl_ko});
      prev <= {p_r1, p_r0};
      scnt <= state_n != state ? '0 : run;
      tcnt <= state_n != state ? '0 : waiting ? tcnt + 1'b1 : tcnt;
      res_p <= res_p_n;
      res_err <= res_err_n;
      res_valid <= state_n == RESULT;
      op_ready <= state_n == IDLE && ko_s;
      ncl_ki <= state_n == WAIT_DATA;
      ncl_a_r1 <= accept ? op_a : state_n == WAIT_DATA ? ncl_a_r1 : '0;
      ncl_a_r0 <= accept ? ~op_a : state_n == WAIT_DATA ? ncl_a_r0 : '0;
      ncl_b_r1 <= accept ? op_b : state_n == WAIT_DATA ? ncl_b_r1 : '0;
      ncl_b_r0 <= accept ? ~op_b : state_n == WAIT_DATA ? ncl_b_r0 : '0;
    end
endmodule

// File: tb/tb_ncl_mult3_host.sv
// tb_ncl_mult3_host: scoreboard bench with a behavioural NCL multiplier model
module tb_ncl_mult3_host;
  localparam int TMO = 255;
  localparam int M_NORM = 0, M_STAG = 1, M_ILL = 2, M_HANG = 3;
  logic clk = 0, rst = 1, op_valid = 0, res_ready = 1, ncl_ko = 1;
  logic op_ready, res_valid, res_err, ncl_ki;
  logic [2:0] op_a = 0, op_b = 0, a_r1, a_r0, b_r1, b_r0;
  logic [5:0] res_p, po_r1 = 0, po_r0 = 0;
  int n_chk = 0, n_fail = 0, n_acc = 0, n_res = 0, mode = M_NORM;
  bit hold_ko0 = 0, rr_rand = 0, busy_viol = 0;
  longint cyc = 0, t_acc = 0;
  typedef struct {
    logic [5:0] p;
    logic err;
    int min_lat;
  } exp_t;
  exp_t sb[$];
  logic ki_hist[$];

  ncl_mult3_host dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_err(res_err),
    .ncl_a_r1(a_r1), .ncl_a_r0(a_r0), .ncl_b_r1(b_r1), .ncl_b_r0(b_r0), .ncl_ki(ncl_ki),
    .ncl_po_r1(po_r1), .ncl_po_r0(po_r0), .ncl_ko(ncl_ko)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d results expected %0d", n_res, n_acc);
    $fatal(1, "watchdog");
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Behavioural multiplier: four-phase DATA/NULL with selectable misbehaviour
  initial begin : model
    int ph, c;
    logic [5:0] p;
    ph = 0;
    c = 0;
    forever begin
      @(negedge clk);
      #1;
      p = 6'({3'b000, a_r1} * {3'b000, b_r1});
      if (rst) begin
        ph = 0;
        ncl_ko = !hold_ko0;
        po_r1 = 0;
        po_r0 = 0;
      end else if (hold_ko0) ncl_ko = 0;
      else if (ph == 0) begin
        ncl_ko = 1;
        if (ncl_ki && ((a_r1 ^ a_r0) & (b_r1 ^ b_r0)) == 3'b111) begin
          ph = 1;
          c = 0;
        end
      end else if (ph == 1 && !ncl_ki && {a_r1, a_r0, b_r1, b_r0} == 12'd0) begin
        ph = 0;
        po_r1 = 0;
        po_r0 = 0;
        ncl_ko = 1;
      end else if (ph == 1) begin
        c++;
        if (mode == M_NORM || mode == M_ILL) begin
          if (c == 2) begin
            po_r1 = p;
            po_r0 = ~p;
            if (mode == M_ILL) begin
              po_r1[2] = 1;
              po_r0[2] = 1;
            end
          end
          if (c == 3) begin
            ncl_ko = 0;
            ph = 2;
          end
        end else if (mode == M_STAG) begin
          if (c == 3) ncl_ko = 0;
          for (int i = 0; i < 6; i++) if (i <= c) begin
            po_r1[i] = p[i];
            po_r0[i] = !p[i];
          end
          if (c == 5) begin
            po_r1[0] = !p[0];
            po_r0[0] = p[0];
          end
          if (c == 6) ph = 2;
        end
      end else if (ph == 2) begin
        if (!ncl_ki && {a_r1, a_r0, b_r1, b_r0} == 12'd0) begin
          ph = 3;
          c = 0;
        end
      end else begin
        c++;
        if (c == 2) begin
          po_r1 = 0;
          po_r0 = 0;
        end
        if (c == 3) begin
          ncl_ko = 1;
          ph = 0;
        end
      end
    end
  end

  // Monitor: pops expected results on each handshake and watches hold/ready rules
  initial begin : monitor
    exp_t e;
    logic [6:0] held_v;
    bit held;
    logic ki_prev;
    held = 0;
    ki_prev = 0;
    forever begin
      @(posedge clk);
      #3;
      if (ncl_ki !== ki_prev) begin
        ki_hist.push_back(ncl_ki);
        ki_prev = ncl_ki;
      end
      if (rst) begin
        busy_viol = 0;
        held = 0;
        continue;
      end
      if (n_acc > n_res && op_ready) busy_viol = 1;
      if (held) chk("res_hold", {res_valid, res_err, res_p}, {1'b1, held_v});
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got p=%0d err=%0d with nothing expected", res_p, res_err);
        end else begin
          e = sb.pop_front();
          chk("res_p", res_p, e.p);
          chk("res_err", res_err, e.err);
          chk("rails_null", {a_r1, a_r0, b_r1, b_r0, ncl_ki}, 0);
          chk("latency_min", (cyc - t_acc) >= e.min_lat, 1);
          chk("op_ready_busy", busy_viol, 0);
        end
        busy_viol = 0;
        n_res++;
      end
      held = res_valid && !res_ready;
      held_v = {res_err, res_p};
    end
  end

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input int m, input bit expect_res);
    exp_t e;
    int w;
    w = 0;
    mode = m;
    while (!op_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_ready_wait: got 0 expected 1 within 2000 cycles");
      return;
    end
    e.p = (m == M_NORM || m == M_STAG) ? 6'({3'b000, a} * {3'b000, b}) : 6'd0;
    e.err = !(m == M_NORM || m == M_STAG);
    e.min_lat = m == M_HANG ? TMO : 0;
    if (expect_res) sb.push_back(e);
    op_a = a;
    op_b = b;
    op_valid = 1;
    @(negedge clk);
    op_valid = 0;
    t_acc = cyc;
    n_acc++;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (n_res < n_acc && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk(nm, n_res, n_acc);
  endtask

  initial begin : stim
    int w;
    bit v;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {op_ready, res_valid, res_p, res_err, ncl_ki, a_r1, a_r0, b_r1, b_r0}, 0);
    rst = 0;
    issue(3'd5, 3'd6, M_NORM, 1);
    drain("drain_5x6");
    chk("ki_seq_len", ki_hist.size(), 2);
    if (ki_hist.size() == 2) begin
      chk("ki_seq_first", ki_hist[0], 1);
      chk("ki_seq_second", ki_hist[1], 0);
    end
    issue(3'd7, 3'd7, M_NORM, 1);
    issue(3'd0, 3'd3, M_NORM, 1);
    drain("drain_b2b");
    issue(3'd2, 3'd3, M_HANG, 1);
    drain("drain_timeout");
    issue(3'd3, 3'd4, M_ILL, 1);
    drain("drain_illegal");
    issue(3'd5, 3'd7, M_STAG, 1);
    drain("drain_stagger");
    issue(3'd4, 3'd5, M_HANG, 0);
    repeat (10) @(negedge clk);
    hold_ko0 = 1;
    rst = 1;
    n_acc--;
    @(negedge clk);
    chk("midop_reset_outputs", {op_ready, res_valid, res_p, res_err, ncl_ki, a_r1, a_r0, b_r1, b_r0}, 0);
    rst = 0;
    v = 0;
    repeat (8) begin
      @(negedge clk);
      if (op_ready) v = 1;
    end
    chk("ready_before_ko", v, 0);
    hold_ko0 = 0;
    w = 0;
    while (!op_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ready_after_ko", op_ready, 1);
    rr_rand = 1;
    for (int i = 0; i < 20; i++)
      issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 1) ? M_STAG : M_NORM, 1);
    drain("drain_random");
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ncl_mult3_host.md
NCL_MULT3_HOST -- requirements
Module: ncl_mult3_host

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop stages on every asynchronous input (ncl_ko, ncl_po_r1, ncl_po_r0).
REQ-002 Parameter STABLE_CYC, default 2: consecutive identical complete samples required to accept a product wavefront.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum cycles spent in WAIT_DATA or WAIT_NULL.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 rst  in  1  reset: synchronous, active-high.
REQ-006 op_valid  in  1  operand pair offered.
REQ-007 op_ready  out  1  operand pair accepted when op_valid & op_ready.
REQ-008 op_a, op_b  in  3 each  unsigned operands.
REQ-009 res_valid  out  1  result available.
REQ-010 res_ready  in  1  result consumed when res_valid & res_ready.
REQ-011 res_p  out  6  unsigned product.
REQ-012 res_err  out  1  result invalid: timeout or illegal rail code.
REQ-013 ncl_a_r1, ncl_a_r0, ncl_b_r1, ncl_b_r0  out  3 each  dual-rail operand drive to the NCL multiplier.
REQ-014 ncl_ki  out  1  acknowledge into the multiplier: 1 = request-for-data, 0 = request-for-NULL.
REQ-015 ncl_po_r1, ncl_po_r0  in  6 each  dual-rail product from the multiplier (asynchronous).
REQ-016 ncl_ko  in  1  multiplier acknowledge (asynchronous): 1 = ready for DATA, 0 = ready for NULL.

Function
REQ-017 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-018 Dual-rail encoding SHALL be: NULL = (r1,r0) = 00; DATA0 = 01; DATA1 = 10; 11 is illegal.
REQ-019 The FSM SHALL have states IDLE, WAIT_DATA, SEND_NULL, WAIT_NULL and RESULT.
REQ-020 IDLE: op_ready SHALL equal synchronized ko = 1; operand rails SHALL be NULL; ncl_ki SHALL be 0.
REQ-021 IDLE -> WAIT_DATA on op_valid & op_ready: capture op_a/op_b, drive their DATA encoding on the next edge, and set ncl_ki = 1.
REQ-022 WAIT_DATA: product is complete when all 6 synchronized bit pairs are 01 or 10.
REQ-023 WAIT_DATA -> SEND_NULL when the product is complete, identical for STABLE_CYC consecutive samples, and synchronized ko = 0; latch the decoded rail1 bits into res_p.
REQ-024 SEND_NULL SHALL last one cycle: operand rails NULL, ncl_ki = 0, then move to WAIT_NULL.
REQ-025 WAIT_NULL -> RESULT when all 12 synchronized product rails are 0 for STABLE_CYC consecutive samples and synchronized ko = 1.
REQ-026 RESULT: res_valid = 1, held with res_p and res_err stable until res_ready; then return to IDLE.
REQ-027 Any synchronized product pair = 11 in WAIT_DATA SHALL set res_err = 1 and res_p = 0, then go to SEND_NULL.
REQ-028 The timeout counter SHALL clear on every state entry and increment each cycle in WAIT_DATA and WAIT_NULL.
REQ-029 When the timeout counter reaches TIMEOUT_CYC: set res_err = 1 and res_p = 0. From WAIT_DATA go to SEND_NULL; from WAIT_NULL go to RESULT.
REQ-030 A changing sample in WAIT_DATA or WAIT_NULL SHALL restart the stability count without error.
REQ-031 Only one operation SHALL be outstanding; op_ready = 0 in all states except IDLE.
REQ-032 res_err SHALL clear when the next operand pair is accepted.

Reset
REQ-033 While rst = 1: state = IDLE; every operand rail = 0; ncl_ki = 0; op_ready = 0; res_valid = 0; res_p = 0; res_err = 0; all counters and synchronizer flops = 0.
REQ-034 rst asserted mid-operation SHALL abort immediately to the reset values; the in-flight result is discarded.
REQ-035 After rst deasserts, op_ready SHALL rise only once synchronized ko = 1 (the multiplier has flushed to NULL).

Structure
REQ-036 Package ncl_host_pkg SHALL hold the FSM state enum, the rail-code constants (NULL, DATA0, DATA1) and the dual-rail struct typedef shared with the NCL gate library.
REQ-037 One sub-module ncl_dr_sync SHALL provide the parameterized N-pair synchronizer with per-pair complete, all-null and illegal flags.

Verification
REQ-038 Reset, then a behavioural NCL multiplier model; a=5, b=6 -> res_p = 30, res_err = 0; rails return to NULL; ncl_ki sequence 1 then 0.
REQ-039 Back-to-back ops 7x7 then 0x3 with res_ready held high -> res_p = 49, then 0; op_ready = 0 between them until ko returns to 1.
REQ-040 Model holds ncl_ko = 1 and drives no product after a=2, b=3 -> res_err = 1 and res_p = 0 after TIMEOUT_CYC cycles; rails go NULL.
REQ-041 Model drives bit 2 as 11 -> res_err = 1; FSM passes through SEND_NULL and WAIT_NULL and then presents RESULT.
REQ-042 Product bits arrive staggered over 5 cycles with one glitch -> a single result equal to the final stable value of a x b.
REQ-043 rst pulsed during WAIT_DATA -> all outputs at reset values the next cycle; op_ready = 0 until ko = 1 is synchronized.
